md_unit: RTL
============

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits in EX, directly downstream of the forwarding muxes, and takes the already-bypassed rs/rt values as operands.
- Exposes busy so the hazard unit can stall later mult/div/mfhi/mflo/mthi/mtlo instructions.
- Keeps the ALU path single-cycle.

Parameters:
- MULT_CYCLES, 5: cycles busy is high for mult/multu (and madd/maddu), at least 1.
- DIV_CYCLES, 10: cycles busy is high for div/divu, at least 1.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- start  input  1  one-cycle request qualifier from EX.
- op  input  3  operation code; encoding in the shared package.
- rs_data  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
- rt_data  input  32  forwarded rt operand (divisor / multiplier).
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, counter=0, pending result cleared. Reset mid-operation drops the operation; HI/LO stay 0.
- Request accepted on a rising edge where start=1 and busy=0. A start while busy=1 is ignored with no state change; the hazard unit must stall such requests.
- mult/multu/div/divu:
  - Operands are latched and the 64-bit result is computed at the accepting edge.
  - The counter loads MULT_CYCLES or DIV_CYCLES; busy = (counter != 0), so busy is high for exactly N cycles starting the cycle after acceptance.
  - On the edge where the counter goes 1 to 0, {hi,lo} take the pending result. New hi/lo are visible in the first cycle busy=0.
  - hi/lo hold their old values while busy.
- mthi/mtlo:
  - On the accepting edge, hi (or lo) = rs_data. No busy cycle.
  - Next-cycle readout is the new value.
- mult: signed 32x32 to 64; hi = upper half, lo = lower half.
- multu: unsigned 32x32 to 64; same hi/lo split.
- div: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned; lo = quotient, hi = remainder.
- Divide by zero (div and divu): lo=0xFFFFFFFF, hi=rs_data. No exception; busy timing unchanged.
- Unused op codes with start=1: no effect, busy stays 0.
- Outputs are registers only; no combinational path from inputs to hi/lo/busy.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: op codes MADD (signed) and MADDU (unsigned) are legal. Result = {hi,lo} + product, mod 2^64, with {hi,lo} sampled at the accepting edge. Busy = MULT_CYCLES.
- Undefined: those codes are treated as unused (no effect).

Decomposition:
- Shared package md_pkg holds:
  - op encoding: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, MD_MADD=6, MD_MADDU=7;
  - default latency constants;
  - the 64-bit result width constant.
- One natural sub-module, md_calc: purely combinational. Takes op, operands and the current {hi,lo}; returns the 64-bit result, including divide-by-zero and overflow special cases.
- md_unit keeps the counter, pending register and HI/LO.

Test Plan:
- Signed multiply: start, op=MULT, rs=3, rt=0xFFFFFFFE -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned multiply: op=MULTU, rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide and overflow case:
  - op=DIV, rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - op=DIV, rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: op=DIVU, rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678.
- Start while busy: during a MULT, pulse start with op=MTHI, rs=0xDEADBEEF in busy cycle 2 -> ignored; final hi/lo are the MULT result. MTHI after busy falls -> hi=0xDEADBEEF next cycle, busy stays 0.
- Reset mid-operation: drive reset=0 asynchronously in busy cycle 3 of a DIV -> busy=0, hi=lo=0 immediately. After release, no late write-back occurs.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: op encoding, default latencies and result width shared by the md_unit files
package md_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MADDU = 3'd7
  } md_op_e;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES = 10;
  localparam int MD_RES_W = 64;
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit {hi,lo} result for mult/div/madd ops, incl. divide-by-zero and overflow
module md_calc
  import md_pkg::*;
(
  input  logic [2:0]          op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  input  logic [MD_RES_W-1:0] acc,
  output logic [MD_RES_W-1:0] res
);
  logic [63:0] sprod, uprod;
  logic [31:0] ua, ub, uq, ur, sq, sr;
  always_comb begin
    sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    uprod = {32'b0, a} * {32'b0, b};
    // signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000
    ua = a[31] ? -a : a;
    ub = b[31] ? -b : b;
    uq = ua / ub;
    ur = ua % ub;
    sq = (a[31] ^ b[31]) ? -uq : uq;
    sr = a[31] ? -ur : ur;
    res = ((op == MD_DIV || op == MD_DIVU) && b == '0) ? {a, 32'hFFFF_FFFF} :
          op == MD_MULT  ? sprod :
          op == MD_MULTU ? uprod :
          op == MD_DIV   ? {sr, sq} :
          op == MD_DIVU  ? {a % b, a / b} :
          op == MD_MADD  ? acc + sprod :
          op == MD_MADDU ? acc + uprod : acc;
  end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/div unit with HI/LO registers and busy for hazard stalls
// Define MD_MADD_EN to make madd/maddu legal ops.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [CW-1:0] cnt;
  logic [MD_RES_W-1:0] pend, res;
  logic acc_ok, is_mul, is_div, is_madd;
`ifdef MD_MADD_EN
  assign is_madd = op == MD_MADD || op == MD_MADDU;
`else
  assign is_madd = 1'b0;
`endif
  assign is_mul = op == MD_MULT || op == MD_MULTU || is_madd;
  assign is_div = op == MD_DIV || op == MD_DIVU;
  assign acc_ok = start && !busy;
  assign busy = cnt != '0;
  md_calc u_calc (
    .op  (op),
    .a   (rs_data),
    .b   (rt_data),
    .acc ({hi, lo}),
    .res (res)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      cnt  <= '0;
      pend <= '0;
    end else if (acc_ok && (is_mul || is_div)) begin
      cnt  <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      pend <= res;
    end else if (acc_ok && op == MD_MTHI) begin
      hi <= rs_data;
    end else if (acc_ok && op == MD_MTLO) begin
      lo <= rs_data;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) {hi, lo} <= pend;
    end
  end
endmodule
